rr_req_encoder: RTL and testbench
=================================

# rr_req_encoder

Round-robin request encoder that sits directly upstream of the 3-to-8 decoder stage. It latches eight independent request lines into a pending register and picks one pending request at a time in round-robin order. The pick is presented as a 3-bit code plus a valid flag, which drive the decoder's `in` and `enable`. A ready/valid handshake retires each request exactly once.

## Interface
- `IN`, 8: number of request lines; fixed at 8 for this revision.
- `OUT`, 3: width of the output code, equal to log2(`IN`).
- `clk`  input  1  the single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  `IN`  request strobes; a 1 on bit i for one or more cycles sets pending bit i.
- `out_ready`  input  1  downstream accepts the current code this cycle.
- `code`  output  `OUT`  index of the granted request; drives decoder `in`.
- `code_valid`  output  1  `code` is valid; drives decoder `enable`.
- `pending`  output  `IN`  registered pending-request vector, for status readback.

## Operation
- Pending register update each cycle: `pending <= (pending & ~clr) | req`.
  - `clr` is onehot(`code`) when `code_valid && out_ready`, otherwise 0.
  - If `req[i]` is high in the same cycle bit i is cleared, the bit stays set. The request re-arms and is served again later.
- Round-robin pointer `ptr` (`OUT` bits):
  - Search order is `ptr`, `ptr+1`, … , `ptr+7`, with indices taken mod 8.
  - The first set bit in the searched vector wins.
  - On each accepted grant, `ptr` becomes `code+1` mod 8; a grant of 7 wraps `ptr` to 0.
  - `ptr` does not change when no grant is accepted.
- State machine, two states:
  - IDLE: `code_valid`=0.
    - If registered `pending` != 0, pick from `pending`, load `code`, and go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD: `code_valid`=1, and `code` is held stable until accepted.
    - If `out_ready`=0, stay in HOLD and change nothing.
    - If `out_ready`=1, retire the current code and compute `rem = pending & ~onehot(code)`.
    - If `rem` != 0, pick from `rem` using the updated pointer (`code+1`), load the new `code`, and stay in HOLD. This gives back-to-back grants with no bubble.
    - If `rem` == 0, go to IDLE.
- `req` bits arriving in the acceptance cycle are not visible to that cycle's pick. They are considered from the following cycle.
- `code` keeps its last value in IDLE. Consumers must gate on `code_valid`.

## Timing
- Reset values: `pending`=0, `code`=0, `code_valid`=0, `ptr`=0, state IDLE.
- Reset asserted in HOLD drops the outstanding grant; no acceptance is recorded.
- Latency:
  - `req` sampled high at edge N sets `pending` after edge N.
  - `code_valid` rises after edge N+1, i.e. 2 cycles from request to grant.
- Throughput: one grant per cycle while `out_ready`=1 and requests remain pending.
- Stall: with `out_ready`=0, `code` and `code_valid` are stable indefinitely while `pending` keeps accumulating.
- All outputs are registered; there is no combinational path from `req` or `out_ready` to any output.

## Structure
- Shared package `rr_req_pkg`:
  - constants `RR_IN`=8 and `RR_OUT`=3;
  - state enum {ST_IDLE, ST_HOLD};
  - function `onehot8(code)`.
- Sub-module `rr_pick8`: combinational round-robin picker.
  - Inputs: `vec[7:0]`, `ptr[2:0]`.
  - Outputs: `idx[2:0]`, `any`.
  - Instantiated once; its vector input is muxed between `pending` (IDLE) and `rem` (HOLD accept).

## Test plan
- Reset, then no requests for 20 cycles → `code_valid`=0, `pending`=0 throughout.
- `req`=8'h04 for one cycle, `out_ready`=1 → `code_valid`=1 with `code`=2 two cycles later for exactly one cycle; `pending` returns to 0.
- `req`=8'hFF for one cycle, `out_ready`=1 → codes 0,1,2,…,7 on 8 consecutive cycles, then `code_valid`=0.
- Grant code 7 accepted, then `req`=8'h81 → next code is 0 (pointer wrapped), then 7.
- `req`=8'h10 with `out_ready`=0 for 5 cycles → `code`=4 held with `code_valid`=1; raising `out_ready` retires it in one cycle.
  - Repeat with `req[4]` asserted in the acceptance cycle → code 4 is granted again.
- Reset asserted while in HOLD with `pending`=8'h0C → next cycle all outputs 0, and no grant appears afterwards.

Source files
------------

// File: rtl/rr_req_pkg.sv
// Shared constants, state encoding and one-hot helper for the round-robin request encoder.
package rr_req_pkg;

  localparam int unsigned RR_IN  = 8;
  localparam int unsigned RR_OUT = 3;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_HOLD
  } rr_state_e;

  function automatic logic [RR_IN-1:0] onehot8(input logic [RR_OUT-1:0] code);
    logic [RR_IN-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_req_encoder_pick8.sv
// Combinational round-robin picker: first set bit of vec searching from ptr upwards, mod 8.
module rr_pick8
  import rr_req_pkg::*;
(
  input  logic [RR_IN-1:0]  vec,
  input  logic [RR_OUT-1:0] ptr,
  output logic [RR_OUT-1:0] idx,
  output logic              any
);

  logic [RR_OUT-1:0] pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < RR_IN; i++) begin
      pos = ptr + RR_OUT'(i);
      if (!any && vec[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_req_encoder.sv
// Latches request strobes into a pending vector and grants them one at a time in round-robin
// order through a registered code/valid handshake.
module rr_req_encoder
  import rr_req_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [RR_IN-1:0]  req,
  input  logic              out_ready,
  output logic [RR_OUT-1:0] code,
  output logic              code_valid,
  output logic [RR_IN-1:0]  pending
);

  rr_state_e         state_q, state_d;
  logic [RR_OUT-1:0] code_q, code_d;
  logic [RR_OUT-1:0] ptr_q, ptr_d;
  logic [RR_IN-1:0]  pending_q, pending_d;

  logic              accept;
  logic [RR_IN-1:0]  code_oh;
  logic [RR_IN-1:0]  rem;
  logic [RR_IN-1:0]  pick_vec;
  logic [RR_OUT-1:0] pick_ptr;
  logic [RR_OUT-1:0] pick_idx;
  logic              pick_any;

  assign accept  = (state_q == ST_HOLD) && out_ready;
  assign code_oh = onehot8(code_q);
  assign rem     = pending_q & ~code_oh;

  // In HOLD the picker only matters on acceptance, where it must skip the retiring code.
  assign pick_vec = (state_q == ST_HOLD) ? rem : pending_q;
  assign pick_ptr = accept ? code_q + RR_OUT'(1) : ptr_q;

  rr_pick8 u_pick (
    .vec (pick_vec),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    ptr_d     = ptr_q;
    pending_d = (pending_q & ~(accept ? code_oh : '0)) | req;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          code_d  = pick_idx;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          ptr_d = pick_ptr;
          if (pick_any) begin
            code_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
    end
  end

  assign code       = code_q;
  assign code_valid = (state_q == ST_HOLD);
  assign pending    = pending_q;

endmodule

// File: tb/tb_rr_req_encoder.sv
// Directed bench for rr_req_encoder: per-cycle vector table plus hand-written stall/reset sequences.
module tb_rr_req_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       out_ready;
  logic [2:0] code;
  logic       code_valid;
  logic [7:0] pending;

  int checks   = 0;
  int failures = 0;

  rr_req_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .out_ready  (out_ready),
    .code       (code),
    .code_valid (code_valid),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // One row = inputs held for one cycle, expected outputs just after the following edge.
  typedef struct {
    logic       rst;
    logic [7:0] rq;
    logic       rdy;
    logic [2:0] ecode;
    logic       chk_code;
    logic       evalid;
    logic [7:0] epend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic rdy,
                              input logic [2:0] ec, input logic cc, input logic ev,
                              input logic [7:0] ep);
    vec_t v;
    v.rst = r; v.rq = rq; v.rdy = rdy; v.ecode = ec; v.chk_code = cc; v.evalid = ev;
    v.epend = ep;
    return v;
  endfunction

  task automatic cyc(input logic r, input logic [7:0] rq, input logic rdy, input logic [2:0] ec,
                     input logic cc, input logic ev, input logic [7:0] ep, input string nm);
    reset     = r;
    req       = rq;
    out_ready = rdy;
    @(posedge clk);
    #1;
    checks++;
    if (code_valid !== ev) begin
      failures++;
      $display("FAIL %s code_valid: got %0b expected %0b", nm, code_valid, ev);
    end
    checks++;
    if (pending !== ep) begin
      failures++;
      $display("FAIL %s pending: got %02h expected %02h", nm, pending, ep);
    end
    if (cc) begin
      checks++;
      if (code !== ec) begin
        failures++;
        $display("FAIL %s code: got %0d expected %0d", nm, code, ec);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    out_ready = 1'b0;

    // Reset values.
    vecs.push_back(mk(1, 8'h00, 0, 3'd0, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'h00, 0, 3'd0, 1, 0, 8'h00));
    // Single request on line 2: two cycles to grant, one-cycle grant.
    vecs.push_back(mk(0, 8'h04, 1, 3'd0, 1, 0, 8'h04));
    vecs.push_back(mk(0, 8'h00, 1, 3'd2, 1, 1, 8'h04));
    vecs.push_back(mk(0, 8'h00, 1, 3'd2, 1, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 3'd2, 1, 0, 8'h00));
    // Reset pointer, then all eight lines: codes 0..7 back to back.
    vecs.push_back(mk(1, 8'h00, 0, 3'd0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 8'hFF, 1, 3'd0, 1, 0, 8'hFF));
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(0, 8'h00, 1, 3'(k), 1, 1, 8'(8'hFF << k)));
    end
    vecs.push_back(mk(0, 8'h00, 1, 3'd7, 1, 0, 8'h00));
    // Move pointer to 6 via line 5, then grant 7 which must wrap the pointer to 0.
    vecs.push_back(mk(0, 8'h20, 1, 3'd7, 1, 0, 8'h20));
    vecs.push_back(mk(0, 8'h00, 1, 3'd5, 1, 1, 8'h20));
    vecs.push_back(mk(0, 8'h00, 1, 3'd5, 1, 0, 8'h00));
    vecs.push_back(mk(0, 8'h80, 1, 3'd5, 1, 0, 8'h80));
    vecs.push_back(mk(0, 8'h00, 1, 3'd7, 1, 1, 8'h80));
    vecs.push_back(mk(0, 8'h00, 1, 3'd7, 1, 0, 8'h00));
    vecs.push_back(mk(0, 8'h81, 1, 3'd7, 1, 0, 8'h81));
    vecs.push_back(mk(0, 8'h00, 1, 3'd0, 1, 1, 8'h81));
    vecs.push_back(mk(0, 8'h00, 1, 3'd7, 1, 1, 8'h80));
    vecs.push_back(mk(0, 8'h00, 1, 3'd7, 1, 0, 8'h00));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].rq, vecs[i].rdy, vecs[i].ecode, vecs[i].chk_code,
          vecs[i].evalid, vecs[i].epend, $sformatf("vec%0d", i));
    end

    // Quiet period: nothing pending, nothing granted.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 8'h00, 1, 3'd7, 1, 0, 8'h00, $sformatf("idle%0d", i));
    end

    // Stall: line 4 held for 5 cycles, then retired in one accepting cycle. Pointer -> 5.
    cyc(0, 8'h10, 0, 3'd7, 1, 0, 8'h10, "stall_req");
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 0, 3'd4, 1, 1, 8'h10, $sformatf("stall%0d", i));
    end
    cyc(0, 8'h00, 1, 3'd4, 1, 0, 8'h00, "stall_accept");
    cyc(0, 8'h00, 1, 3'd4, 1, 0, 8'h00, "stall_after");

    // Re-arm: pending accumulates line 0 during stall; line 4 re-requested while retiring.
    cyc(0, 8'h10, 0, 3'd4, 1, 0, 8'h10, "rearm_req");
    cyc(0, 8'h01, 0, 3'd4, 1, 1, 8'h11, "rearm_accum");
    cyc(0, 8'h00, 0, 3'd4, 1, 1, 8'h11, "rearm_stall");
    cyc(0, 8'h10, 1, 3'd0, 1, 1, 8'h11, "rearm_accept");
    cyc(0, 8'h00, 1, 3'd4, 1, 1, 8'h10, "rearm_again");
    cyc(0, 8'h00, 1, 3'd4, 1, 0, 8'h00, "rearm_done");

    // Reset while holding code 2 (pointer 5) with lines 2 and 3 pending.
    cyc(0, 8'h0C, 0, 3'd4, 1, 0, 8'h0C, "rst_req");
    cyc(0, 8'h00, 0, 3'd2, 1, 1, 8'h0C, "rst_hold");
    cyc(1, 8'h00, 0, 3'd0, 1, 0, 8'h00, "rst_apply");
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1, 3'd0, 1, 0, 8'h00, $sformatf("rst_after%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
